// File: rtl/ifu_ibuf_pkg.sv
// Shared widths for the IFU instruction buffer.
// An entry is {err, pc, instr}, packed MSB to LSB.
package ifu_ibuf_pkg;

    localparam int unsigned IBUF_AW = 32;
    localparam int unsigned IBUF_DW = 32;
    localparam int unsigned IBUF_EW = 1 + IBUF_AW + IBUF_DW;

    function automatic int unsigned ibuf_ew(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/ifu_ibuf_if.sv
// Carries the fetch-response channel and the decode-side channel of the instruction buffer.
// The slave modport is the buffer's own view; master is the surrounding IFU and decode.
interface ifu_ibuf_if
    import ifu_ibuf_pkg::*;
#(
    parameter int unsigned AW = IBUF_AW,
    parameter int unsigned DW = IBUF_DW
);
    logic          i_rsp_valid;
    logic          o_rsp_ready;
    logic          i_rsp_err;
    logic [DW-1:0] i_rsp_instr;
    logic [AW-1:0] i_rsp_pc;

    logic          o_ir_valid;
    logic          i_ir_ready;
    logic [DW-1:0] o_ir_instr;
    logic [AW-1:0] o_ir_pc;
    logic          o_ir_err;

    modport slave (
        input  i_rsp_valid, i_rsp_err, i_rsp_instr, i_rsp_pc, i_ir_ready,
        output o_rsp_ready, o_ir_valid, o_ir_instr, o_ir_pc, o_ir_err
    );

    modport master (
        output i_rsp_valid, i_rsp_err, i_rsp_instr, i_rsp_pc, i_ir_ready,
        input  o_rsp_ready, o_ir_valid, o_ir_instr, o_ir_pc, o_ir_err
    );
endinterface

// File: rtl/ifu_ibuf_fifo_ram.sv
// Register-array storage for the instruction buffer: one write port and one
// asynchronous read port. The contents are not reset; occupancy is tracked outside.
module ibuf_fifo_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 65
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ifu_ibuf.sv
// Instruction buffer between the IFU fetch response and decode. A flush empties
// the buffer and opens a window that swallows wrong-path responses still in flight.
module ifu_ibuf
    import ifu_ibuf_pkg::*;
#(
    parameter int unsigned AW       = IBUF_AW,
    parameter int unsigned DW       = IBUF_DW,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned KILL_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    ifu_ibuf_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned EW = ibuf_ew(AW, DW);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = 3;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [KW-1:0] kill_q, kill_d;

    logic          push;
    logic          pop;
    logic          not_empty;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign not_empty       = (count_q != '0);
    assign bus.o_rsp_ready = (count_q != CW'(DEPTH)) | (kill_q != '0);
    assign bus.o_ir_valid  = not_empty;

    assign push = bus.i_rsp_valid & bus.o_rsp_ready & ~i_flush & (kill_q == '0);
    assign pop  = not_empty & bus.i_ir_ready & ~i_flush;

    assign wdata = {bus.i_rsp_err, bus.i_rsp_pc, bus.i_rsp_instr};

    ibuf_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign bus.o_ir_instr = not_empty ? rdata[DW-1:0]     : '0;
    assign bus.o_ir_pc    = not_empty ? rdata[DW+AW-1:DW] : '0;
    assign bus.o_ir_err   = not_empty ? rdata[EW-1]       : 1'b0;
    assign o_count        = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        kill_d   = kill_q;

        if (kill_q != '0) begin
            kill_d = kill_q - KW'(1);
        end

        if (i_flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            kill_d   = KW'(KILL_LAT);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            kill_q   <= kill_d;
        end
    end
endmodule
